// File: rtl/eca_engine.sv
// -----------------------------------------------------------------------------
// eca_engine
//
// Elementary cellular automaton engine. WIDTH cells are held in a register
// array. Each cell updates from its {left, self, right} neighbourhood through
// a runtime-programmable 8-bit rule byte. A start/done handshake runs the
// engine for a programmed number of generations, one generation per clock.
//
// Build option:
//   ECA_WRAP_EN  defined   -> periodic boundary (the two edge cells are
//                             neighbours of each other)
//                undefined -> null boundary (out-of-range neighbours read 0)
//
// Parameters:
//   WIDTH  number of cells (3 or more)
//   CNT_W  width of run_steps and step_count
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   rule_in     rule byte, loaded by rule_we while idle
//   rule_we     rule write strobe
//   seed_in     initial generation
//   seed_valid  seed offer
//   seed_ready  high while idle; a seed loads on seed_valid && seed_ready
//   run_steps   generations to compute, sampled with start
//   start       begins a run while idle
//   busy        high while running
//   done        one-cycle pulse at the end of a run
//   state_out   current generation (bit WIDTH-1 is the leftmost cell)
//   step_count  generations completed in the current or last run (saturating)
// -----------------------------------------------------------------------------
module eca_engine #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rule_in,
   input  logic             rule_we,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             seed_valid,
   output logic             seed_ready,
   input  logic [CNT_W-1:0] run_steps,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] state_out,
   output logic [CNT_W-1:0] step_count
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   localparam logic [7:0]       RULE_RESET = 8'hA6;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   fsm_t             fsm_q, fsm_d;
   logic [7:0]       rule_q, rule_d;
   logic [WIDTH-1:0] gen_q, gen_d;
   logic [WIDTH-1:0] next_gen;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d;

   // Neighbour values seen beyond the two ends of the array.
   logic             left_edge;   // c[WIDTH], left neighbour of the leftmost cell
   logic             right_edge;  // c[-1], right neighbour of cell 0
   logic [WIDTH+1:0] padded;

`ifdef ECA_WRAP_EN
   assign left_edge  = gen_q[0];
   assign right_edge = gen_q[WIDTH-1];
`else
   assign left_edge  = 1'b0;
   assign right_edge = 1'b0;
`endif

   // padded[i+1] is cell i, so padded[i+2 -: 3] is {c[i+1], c[i], c[i-1]}.
   assign padded = {left_edge, gen_q, right_edge};

   always_comb begin
      next_gen = '0;
      for (int i = 0; i < WIDTH; i++) begin
         next_gen[i] = rule_q[padded[i+2 -: 3]];
      end
   end

   // Next-state and datapath control.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so that no path
      // leaves it unassigned, which would infer a latch.
      fsm_d    = fsm_q;
      rule_d   = rule_q;
      gen_d    = gen_q;
      remain_d = remain_q;
      count_d  = count_q;
      done_d   = 1'b0;

      case (fsm_q)
         IDLE: begin
            if (rule_we) begin
               rule_d = rule_in;
            end
            if (seed_valid) begin
               gen_d = seed_in;
            end
            if (start) begin
               count_d = '0;
               if (run_steps != '0) begin
                  remain_d = run_steps;
                  fsm_d    = RUN;
               end else begin
                  // Zero-length run: acknowledge immediately, state untouched.
                  done_d = 1'b1;
               end
            end
         end

         RUN: begin
            gen_d    = next_gen;
            remain_d = remain_q - CNT_ONE;
            if (count_q != '1) begin
               count_d = count_q + CNT_ONE;
            end
            if (remain_q == CNT_ONE) begin
               fsm_d  = IDLE;
               done_d = 1'b1;
            end
         end

         default: fsm_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, giving the simultaneous cell update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= IDLE;
         rule_q   <= RULE_RESET;
         gen_q    <= '0;
         remain_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         rule_q   <= rule_d;
         gen_q    <= gen_d;
         remain_q <= remain_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   assign busy       = (fsm_q == RUN);
   assign seed_ready = ~busy;
   assign done       = done_q;
   assign state_out  = gen_q;
   assign step_count = count_q;

endmodule
